dlx_muldiv_unit: RTL
====================

DLX_MULDIV_UNIT -- requirements
Module: dlx_muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL provide parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on negedge clk, matching the pipeline interstage registers.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, request issued by the ID stage.
REQ-006 SHALL have port op, input, 2 bits, operation code: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 SHALL have port a, input, WIDTH bits, multiplicand or dividend (forwarded rs1).
REQ-008 SHALL have port b, input, WIDTH bits, multiplier or divisor (forwarded rs2).
REQ-009 SHALL have port kill, input, 1 bit, abort of the in-flight operation (branch squash).
REQ-010 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE; drives the pipeline stall.
REQ-011 SHALL have port done, output, 1 bit, one-cycle pulse marking valid hi/lo.
REQ-012 SHALL have port hi, output, WIDTH bits, product upper half or remainder.
REQ-013 SHALL have port lo, output, WIDTH bits, product lower half or quotient.
REQ-014 SHALL have port div_by_zero, output, 1 bit, high together with done when a DIV/DIVU had b==0.

Function
REQ-015 SHALL implement the states IDLE, CALC, FIX, DONE.
REQ-016 SHALL accept start only in IDLE with kill low, capturing op, the operand magnitudes (signed ops) or the raw operands (unsigned ops), and the result signs; accepting loads the counter with WIDTH.
REQ-017 SHALL ignore start in any state other than IDLE; there is no queueing.
REQ-018 SHALL, on acceptance with a non-zero divisor or any multiply, enter CALC and perform one radix-2 shift-add or restoring shift-subtract step per edge, decrementing the counter.
REQ-019 SHALL move CALC->FIX on the edge that performs the final iteration (counter==1), FIX->DONE on the next edge, and DONE->IDLE on the next edge.
REQ-020 SHALL apply two's-complement sign correction in FIX: product negated when the operand signs differ; quotient negated when the signs differ; remainder carries the dividend sign.
REQ-021 SHALL give a total latency from the accepting edge to the done-asserting edge of WIDTH+2 edges; done is high for exactly one cycle (the DONE state).
REQ-022 SHALL, for DIV/DIVU with b==0, go IDLE->DONE on the accepting edge with lo=all ones, hi=a, and div_by_zero=1; latency 1 edge.
REQ-023 SHALL produce lo=most-negative and hi=0 for signed most-negative/-1, with no trap.
REQ-024 SHALL update hi/lo only on the edge entering DONE; they hold until the next completed operation.
REQ-025 SHALL, on kill high in CALC, FIX or DONE, return to IDLE on that edge, suppress done (including a done already scheduled), and leave hi/lo unchanged.
REQ-026 SHALL give kill priority over start when both are high in the same IDLE cycle; start is dropped.
REQ-027 SHALL compute the unsigned product in 2*WIDTH bits with no truncation.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, independent of clk.
REQ-029 SHALL abort any in-flight operation on reset without a done pulse; the first accept is legal on the first negedge after rst_n rises.

Verification (WIDTH=32)
REQ-030 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> done 34 edges after accept, hi=0x00000001, lo=0xFFFFFFFE, busy high throughout.
REQ-031 SHALL cover: MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=5, b=0 -> done 1 edge after accept, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-033 SHALL cover: kill asserted at the 10th CALC edge -> IDLE on that edge, no done, hi/lo retain the previous result; a second start while busy -> ignored.
REQ-034 SHALL cover: rst_n pulsed low between edges mid-CALC -> busy=0, hi=lo=0 immediately; a new MULTU 3*4 -> lo=12 after 34 edges.

Source files
------------

// File: rtl/dlx_muldiv_unit_if.sv
// Request/result bundle between the ID stage and the iterative multiply/divide unit.
interface dlx_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   // start is sampled only while busy is low; busy stays high from the accepting
   // edge until the edge after done, and done is a one-cycle pulse qualifying hi/lo/div_by_zero.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             kill;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
   logic [1:0]       state;

   modport master (
      output start, op, a, b, kill,
      input  busy, done, hi, lo, div_by_zero, state
   );

   modport slave (
      input  start, op, a, b, kill,
      output busy, done, hi, lo, div_by_zero, state
   );
endinterface

// File: rtl/dlx_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: MULT/MULTU shift-add, DIV/DIVU restoring divide.
// State advances on the falling clock edge to line up with the pipeline interstage registers.
module dlx_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic              clk,
   input logic              rst_n,
   dlx_muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   m;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   q;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               b_zero;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Both operations run on magnitudes; signs are re-applied once in FIX.
   always_comb begin
      a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
      b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
      b_zero    = (bus.b == '0);
      mul_sum   = acc + (q[0] ? {1'b0, m} : '0);
      div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, m});
      div_diff  = div_shift - {1'b0, m};
      prod_fix  = neg_res ? -{acc[WIDTH-1:0], q} : {acc[WIDTH-1:0], q};
      quo_fix   = neg_res ? -q : q;
      rem_fix   = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         m       <= '0;
         acc     <= '0;
         q       <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.kill) begin
                  is_div  <= bus.op[1];
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  m       <= b_mag;
                  q       <= a_mag;
                  acc     <= '0;
                  cnt     <= CNT_W'(WIDTH);
                  busy_q  <= 1'b1;
                  if (bus.op[1] && b_zero) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     dbz_q  <= 1'b1;
                     hi_q   <= bus.a;
                     lo_q   <= '1;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.kill) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  if (is_div) begin
                     acc <= div_ge ? div_diff : div_shift;
                     q   <= {q[WIDTH-2:0], div_ge};
                  end else begin
                     acc <= {1'b0, mul_sum[WIDTH:1]};
                     q   <= {mul_sum[0], q[WIDTH-1:1]};
                  end
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= FIX;
               end
            end
            FIX: begin
               if (bus.kill) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  dbz_q  <= 1'b0;
                  if (is_div) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end else begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               dbz_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.state       = state;
endmodule
